// File: rtl/ddr_read_arbiter.sv
// Read-burst arbiter: shares one DDR read port between the instruction cache and the data cache.
// Optional macro DDR_ARB_ISA_PRIO_EN: when defined, ISA wins every simultaneous request (fixed priority).
module ddr_read_arbiter #(
  parameter int DDR_ADDR_WIDTH = 28,
  parameter int DDR_DATA_WIDTH = 64,
  parameter int ISA_WIDTH      = 30,
  parameter int DATA_WIDTH     = 64,
  parameter int LEN_WIDTH      = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ISA_read_req,
  input  logic [DDR_ADDR_WIDTH-1:0] ISA_read_addr,
  input  logic [LEN_WIDTH-1:0]      isa_read_len,
  output logic [ISA_WIDTH-1:0]      instruction_to_cache,
  output logic [LEN_WIDTH-1:0]      rd_cnt_isa,
  output logic                      rd_burst_data_valid_isa,
  input  logic                      DATA_read_req,
  input  logic [DDR_ADDR_WIDTH-1:0] DATA_read_addr,
  input  logic [LEN_WIDTH-1:0]      data_read_len,
  output logic [DATA_WIDTH-1:0]     data_to_cache,
  output logic [LEN_WIDTH-1:0]      rd_cnt_data,
  output logic                      rd_burst_data_valid_data,
  output logic                      rd_burst_req,
  output logic [DDR_ADDR_WIDTH-1:0] rd_burst_addr,
  output logic [LEN_WIDTH-1:0]      rd_burst_len,
  input  logic [DDR_DATA_WIDTH-1:0] rd_burst_data,
  input  logic                      rd_burst_data_valid,
  input  logic                      rd_burst_finish,
  output logic                      grant_isa,
  output logic                      grant_data
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BURST, S_DONE} state_t;

  state_t                    r_state, w_next_state;
  logic                      r_grant_isa, r_grant_data;
  logic [DDR_ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]      r_len;
  logic [ISA_WIDTH-1:0]      r_isa_data;
  logic [DATA_WIDTH-1:0]     r_data_data;
  logic [LEN_WIDTH-1:0]      r_cnt_isa, r_cnt_data;
  logic                      r_valid_isa, r_valid_data;

  logic                      w_any_req, w_pick_isa, w_beat, w_served_req, w_release;
  logic [LEN_WIDTH-1:0]      w_pick_len, w_cnt_cur;

  function automatic logic [LEN_WIDTH-1:0] sat_inc(input logic [LEN_WIDTH-1:0] v);
    return (&v) ? v : v + LEN_WIDTH'(1);
  endfunction

  assign w_any_req    = ISA_read_req | DATA_read_req;
  assign w_pick_len   = w_pick_isa ? isa_read_len : data_read_len;
  assign w_cnt_cur    = r_grant_isa ? r_cnt_isa : r_cnt_data;
  assign w_served_req = r_grant_isa ? ISA_read_req : DATA_read_req;
  assign w_beat       = rd_burst_data_valid && (r_state == S_ISSUE || r_state == S_BURST);
  assign w_release    = (r_state == S_DONE) && !w_served_req;

`ifdef DDR_ARB_ISA_PRIO_EN
  assign w_pick_isa = ISA_read_req;
`else
  // r_rr_isa == 1 means ISA was not the last requester served, so it wins a tie.
  logic r_rr_isa;

  assign w_pick_isa = ISA_read_req && (!DATA_read_req || r_rr_isa);

  always_ff @(posedge clk) begin
    if (rst)            r_rr_isa <= 1'b1;
    else if (w_release) r_rr_isa <= r_grant_data;
  end
`endif

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves w_next_state unassigned (no latch).
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:  if (w_any_req) w_next_state = (w_pick_len == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: if (rd_burst_data_valid) w_next_state = rd_burst_finish ? S_DONE : S_BURST;
      S_BURST: if (rd_burst_finish || (w_cnt_cur >= r_len)) w_next_state = S_DONE;
      S_DONE:  if (!w_served_req) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    rd_burst_req = (r_state == S_ISSUE);
  end

  // Grant, latched request, and per-requester beat delivery.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant_isa  <= 1'b0;
      r_grant_data <= 1'b0;
      r_addr       <= '0;
      r_len        <= '0;
      r_isa_data   <= '0;
      r_data_data  <= '0;
      r_cnt_isa    <= '0;
      r_cnt_data   <= '0;
      r_valid_isa  <= 1'b0;
      r_valid_data <= 1'b0;
    end else begin
      r_valid_isa  <= 1'b0;
      r_valid_data <= 1'b0;
      if (r_state == S_IDLE && w_any_req) begin
        r_addr <= w_pick_isa ? ISA_read_addr : DATA_read_addr;
        r_len  <= w_pick_len;
        if (w_pick_isa) begin
          r_grant_isa <= 1'b1;
          r_cnt_isa   <= '0;
        end else begin
          r_grant_data <= 1'b1;
          r_cnt_data   <= '0;
        end
      end
      if (w_beat) begin
        if (r_grant_isa) begin
          r_isa_data  <= rd_burst_data[ISA_WIDTH-1:0];
          r_valid_isa <= 1'b1;
          r_cnt_isa   <= sat_inc(r_cnt_isa);
        end else begin
          r_data_data  <= rd_burst_data[DATA_WIDTH-1:0];
          r_valid_data <= 1'b1;
          r_cnt_data   <= sat_inc(r_cnt_data);
        end
      end
      if (w_release) begin
        r_grant_isa  <= 1'b0;
        r_grant_data <= 1'b0;
      end
    end
  end

  assign instruction_to_cache     = r_isa_data;
  assign rd_cnt_isa               = r_cnt_isa;
  assign rd_burst_data_valid_isa  = r_valid_isa;
  assign data_to_cache            = r_data_data;
  assign rd_cnt_data              = r_cnt_data;
  assign rd_burst_data_valid_data = r_valid_data;
  assign rd_burst_addr            = r_addr;
  assign rd_burst_len             = r_len;
  assign grant_isa                = r_grant_isa;
  assign grant_data               = r_grant_data;

endmodule

// File: tb/tb_ddr_read_arbiter.sv
// Directed bench for ddr_read_arbiter (default round-robin build): single burst, arbitration order,
// zero length, early finish, finish on the last beat, and reset in the middle of a burst.
module tb_ddr_read_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ISA_read_req;
  logic [27:0] ISA_read_addr;
  logic [9:0]  isa_read_len;
  logic [29:0] instruction_to_cache;
  logic [9:0]  rd_cnt_isa;
  logic        rd_burst_data_valid_isa;
  logic        DATA_read_req;
  logic [27:0] DATA_read_addr;
  logic [9:0]  data_read_len;
  logic [63:0] data_to_cache;
  logic [9:0]  rd_cnt_data;
  logic        rd_burst_data_valid_data;
  logic        rd_burst_req;
  logic [27:0] rd_burst_addr;
  logic [9:0]  rd_burst_len;
  logic [63:0] rd_burst_data;
  logic        rd_burst_data_valid;
  logic        rd_burst_finish;
  logic        grant_isa;
  logic        grant_data;

  int n_checks = 0;
  int n_fail   = 0;

  ddr_read_arbiter dut (
    .clk(clk), .rst(rst),
    .ISA_read_req(ISA_read_req), .ISA_read_addr(ISA_read_addr), .isa_read_len(isa_read_len),
    .instruction_to_cache(instruction_to_cache), .rd_cnt_isa(rd_cnt_isa),
    .rd_burst_data_valid_isa(rd_burst_data_valid_isa),
    .DATA_read_req(DATA_read_req), .DATA_read_addr(DATA_read_addr), .data_read_len(data_read_len),
    .data_to_cache(data_to_cache), .rd_cnt_data(rd_cnt_data),
    .rd_burst_data_valid_data(rd_burst_data_valid_data),
    .rd_burst_req(rd_burst_req), .rd_burst_addr(rd_burst_addr), .rd_burst_len(rd_burst_len),
    .rd_burst_data(rd_burst_data), .rd_burst_data_valid(rd_burst_data_valid),
    .rd_burst_finish(rd_burst_finish), .grant_isa(grant_isa), .grant_data(grant_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle; outputs are read 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [63:0] d, input logic fin);
    rd_burst_data       = d;
    rd_burst_data_valid = 1'b1;
    rd_burst_finish     = fin;
    tick();
    rd_burst_data_valid = 1'b0;
    rd_burst_finish     = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    ISA_read_req = 1'b0;  ISA_read_addr = '0;  isa_read_len = '0;
    DATA_read_req = 1'b0; DATA_read_addr = '0; data_read_len = '0;
    rd_burst_data = '0;   rd_burst_data_valid = 1'b0; rd_burst_finish = 1'b0;
    tick();
    tick();
    check("rst_req",      64'(rd_burst_req), 64'd0);
    check("rst_gi",       64'(grant_isa), 64'd0);
    check("rst_gd",       64'(grant_data), 64'd0);
    check("rst_cnt_isa",  64'(rd_cnt_isa), 64'd0);
    check("rst_cnt_data", 64'(rd_cnt_data), 64'd0);
    check("rst_addr",     64'(rd_burst_addr), 64'd0);

    // Single ISA burst, addr 0x80, 4 beats then finish.
    rst = 1'b0;
    ISA_read_req = 1'b1; ISA_read_addr = 28'h80; isa_read_len = 10'd4;
    tick();
    check("t1_grant_isa", 64'(grant_isa), 64'd1);
    check("t1_req",       64'(rd_burst_req), 64'd1);
    check("t1_addr",      64'(rd_burst_addr), 64'h80);
    check("t1_len",       64'(rd_burst_len), 64'd4);
    tick();
    check("t1_req_hold",  64'(rd_burst_req), 64'd1);
    beat(64'hDEAD_BEEF_C0DE_0001, 1'b0);
    check("t1_cnt1",      64'(rd_cnt_isa), 64'd1);
    check("t1_vld1",      64'(rd_burst_data_valid_isa), 64'd1);
    check("t1_instr1",    64'(instruction_to_cache), 64'h00DE_0001);
    check("t1_req_drop",  64'(rd_burst_req), 64'd0);
    beat(64'h2, 1'b0);
    check("t1_cnt2",      64'(rd_cnt_isa), 64'd2);
    beat(64'h3, 1'b0);
    check("t1_cnt3",      64'(rd_cnt_isa), 64'd3);
    beat(64'h0123_4567_89AB_CDEF, 1'b0);
    check("t1_cnt4",      64'(rd_cnt_isa), 64'd4);
    check("t1_instr4",    64'(instruction_to_cache), 64'h09AB_CDEF);
    check("t1_vd_quiet",  64'(rd_burst_data_valid_data), 64'd0);
    rd_burst_finish = 1'b1;
    tick();
    rd_burst_finish = 1'b0;
    check("t1_done_vld",  64'(rd_burst_data_valid_isa), 64'd0);
    check("t1_done_gi",   64'(grant_isa), 64'd1);
    tick();
    check("t1_hold_gi",   64'(grant_isa), 64'd1);
    ISA_read_req = 1'b0;
    tick();
    check("t1_rel_gi",    64'(grant_isa), 64'd0);
    check("t1_cnt_keep",  64'(rd_cnt_isa), 64'd4);
    check("t1_cnt_data",  64'(rd_cnt_data), 64'd0);

    // Reset so the round-robin pointer starts at ISA again.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t2_rst_cnt",   64'(rd_cnt_isa), 64'd0);

    // Simultaneous requests: ISA first, then DATA wins the next tie.
    ISA_read_req  = 1'b1; ISA_read_addr  = 28'h100; isa_read_len  = 10'd2;
    DATA_read_req = 1'b1; DATA_read_addr = 28'h200; data_read_len = 10'd3;
    tick();
    check("t2_gi",        64'(grant_isa), 64'd1);
    check("t2_gd",        64'(grant_data), 64'd0);
    check("t2_addr",      64'(rd_burst_addr), 64'h100);
    beat(64'h11, 1'b0);
    beat(64'h22, 1'b0);
    check("t2_cnt_isa",   64'(rd_cnt_isa), 64'd2);
    tick();
    check("t2_done_gi",   64'(grant_isa), 64'd1);
    ISA_read_req = 1'b0;
    tick();
    check("t2_rel_gi",    64'(grant_isa), 64'd0);
    check("t2_rel_gd",    64'(grant_data), 64'd0);
    ISA_read_req = 1'b1;
    tick();
    check("t2_tie_gd",    64'(grant_data), 64'd1);
    check("t2_tie_gi",    64'(grant_isa), 64'd0);
    check("t2_addr_d",    64'(rd_burst_addr), 64'h200);
    check("t2_len_d",     64'(rd_burst_len), 64'd3);
    beat(64'hCAFE_0000_0000_0001, 1'b0);
    check("t2_cnt_d1",    64'(rd_cnt_data), 64'd1);
    check("t2_data1",     data_to_cache, 64'hCAFE_0000_0000_0001);
    check("t2_vi_quiet",  64'(rd_burst_data_valid_isa), 64'd0);
    check("t2_cnt_i_hld", 64'(rd_cnt_isa), 64'd2);
    beat(64'h5, 1'b0);
    // Finish coincident with the last beat: the beat is still delivered.
    beat(64'hFEED_FACE_1234_5678, 1'b1);
    check("t2_cnt_d3",    64'(rd_cnt_data), 64'd3);
    check("t2_vld_d3",    64'(rd_burst_data_valid_data), 64'd1);
    check("t2_data3",     data_to_cache, 64'hFEED_FACE_1234_5678);
    DATA_read_req = 1'b0;
    ISA_read_addr = 28'h300; isa_read_len = 10'd4;
    tick();
    check("t2_rel_gd2",   64'(grant_data), 64'd0);

    // Early finish: ISA len 4, finish after beat 3.
    tick();
    check("t3_gi",        64'(grant_isa), 64'd1);
    check("t3_cnt_clr",   64'(rd_cnt_isa), 64'd0);
    check("t3_addr",      64'(rd_burst_addr), 64'h300);
    beat(64'h1, 1'b0);
    beat(64'h2, 1'b0);
    beat(64'h3, 1'b0);
    rd_burst_finish = 1'b1;
    tick();
    rd_burst_finish = 1'b0;
    check("t3_cnt3",      64'(rd_cnt_isa), 64'd3);
    beat(64'h4, 1'b0);
    check("t3_stray_vld", 64'(rd_burst_data_valid_isa), 64'd0);
    check("t3_stray_cnt", 64'(rd_cnt_isa), 64'd3);
    check("t3_hold_gi",   64'(grant_isa), 64'd1);
    ISA_read_req = 1'b0;
    tick();
    check("t3_rel_gi",    64'(grant_isa), 64'd0);

    // Zero-length DATA request.
    DATA_read_req = 1'b1; DATA_read_addr = 28'h40; data_read_len = 10'd0;
    tick();
    check("t4_gd",        64'(grant_data), 64'd1);
    check("t4_req",       64'(rd_burst_req), 64'd0);
    check("t4_cnt",       64'(rd_cnt_data), 64'd0);
    tick();
    check("t4_gd_hold",   64'(grant_data), 64'd1);
    check("t4_req_hold",  64'(rd_burst_req), 64'd0);
    DATA_read_req = 1'b0;
    tick();
    check("t4_rel_gd",    64'(grant_data), 64'd0);

    // Reset after 2 of 8 beats.
    DATA_read_req = 1'b1; DATA_read_addr = 28'h500; data_read_len = 10'd8;
    tick();
    check("t5_req",       64'(rd_burst_req), 64'd1);
    beat(64'hA1, 1'b0);
    beat(64'hA2, 1'b0);
    check("t5_cnt2",      64'(rd_cnt_data), 64'd2);
    rst = 1'b1;
    beat(64'hA3, 1'b0);
    rst = 1'b0;
    DATA_read_req = 1'b0;
    check("t5_rst_cnt",   64'(rd_cnt_data), 64'd0);
    check("t5_rst_vld",   64'(rd_burst_data_valid_data), 64'd0);
    check("t5_rst_gd",    64'(grant_data), 64'd0);
    check("t5_rst_addr",  64'(rd_burst_addr), 64'd0);
    check("t5_rst_data",  data_to_cache, 64'd0);
    check("t5_rst_cnti",  64'(rd_cnt_isa), 64'd0);
    beat(64'hA4, 1'b0);
    check("t5_late_vld",  64'(rd_burst_data_valid_data), 64'd0);
    beat(64'hA5, 1'b0);
    check("t5_late_cnt",  64'(rd_cnt_data), 64'd0);
    check("t5_late_req",  64'(rd_burst_req), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr_read_arbiter.md
Name: ddr_read_arbiter

Overview:
Shares the single DDR read-burst port between the instruction cache (ISA requester) and the data cache (DATA requester). Grants one requester at a time, round-robin by default, and forwards its address and length to the DDR interface. Routes the returning beats, the per-requester beat counters and the valid strobes back to the granted requester. Sits between both caches and the DDR interface module.

Parameters:
DDR_ADDR_WIDTH, 28, DDR byte address width
DDR_DATA_WIDTH, 64, DDR read data width
ISA_WIDTH, 30, instruction width; ISA data is rd_burst_data[ISA_WIDTH-1:0]
DATA_WIDTH, 64, data-cache word width; DATA data is rd_burst_data[DATA_WIDTH-1:0]
LEN_WIDTH, 10, burst length / beat counter width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
ISA_read_req  in  1  ISA request; held until rd_cnt_isa >= isa_read_len
ISA_read_addr  in  DDR_ADDR_WIDTH  ISA burst start address
isa_read_len  in  LEN_WIDTH  ISA burst beats
instruction_to_cache  out  ISA_WIDTH  registered ISA beat
rd_cnt_isa  out  LEN_WIDTH  ISA beats delivered
rd_burst_data_valid_isa  out  1  ISA beat strobe
DATA_read_req  in  1  DATA request; same hold rule
DATA_read_addr  in  DDR_ADDR_WIDTH  DATA burst start address
data_read_len  in  LEN_WIDTH  DATA burst beats
data_to_cache  out  DATA_WIDTH  registered DATA beat
rd_cnt_data  out  LEN_WIDTH  DATA beats delivered
rd_burst_data_valid_data  out  1  DATA beat strobe
rd_burst_req  out  1  burst request to DDR interface
rd_burst_addr  out  DDR_ADDR_WIDTH  latched address of granted requester
rd_burst_len  out  LEN_WIDTH  latched length of granted requester
rd_burst_data  in  DDR_DATA_WIDTH  DDR read beat
rd_burst_data_valid  in  1  beat valid
rd_burst_finish  in  1  one-cycle end-of-burst pulse
grant_isa  out  1  ISA currently owns port
grant_data  out  1  DATA currently owns port

Behaviour:
- Reset (sync, rst=1 at posedge): state IDLE; every output is 0; round-robin pointer = ISA first. Reset during a burst abandons it. DDR beats arriving after reset are ignored until the next grant.
- States: IDLE, ISSUE, BURST, DONE.
- IDLE: when any req is high, select a winner. If both are high, the winner is the requester not served last. On the transition, latch the winner's addr/len into rd_burst_addr/rd_burst_len, clear the winner's rd_cnt to 0, and set its grant. The loser's counter is untouched. If the latched len == 0, go to DONE; otherwise go to ISSUE.
- ISSUE: rd_burst_req=1. Hold it, with addr/len stable, until the first rd_burst_data_valid; then drop it and go to BURST. A beat valid in ISSUE is counted.
- BURST: on each rd_burst_data_valid cycle t, at t+1 the granted side's data output holds that beat, its valid strobe = 1 for one cycle, and its rd_cnt has incremented. Latency is 1 cycle. The non-granted side's strobe stays 0 and its data/cnt are held.
- Counter saturates at 2^LEN_WIDTH-1. Beats beyond rd_burst_len are still forwarded and counted.
- BURST exit: on rd_burst_finish, or when the counter reaches rd_burst_len, go to DONE. Finish and the last valid beat in the same cycle: that beat is still delivered, then DONE.
- DONE: the grant is held, and rd_cnt of the served requester is held (so the requester sees cnt >= len and drops req). Wait until the served req == 0, then clear the grant, flip the round-robin pointer, and go to IDLE. Minimum one cycle in DONE.
- A req deassertion by the granted requester in ISSUE/BURST is ignored; the burst completes.
- rd_cnt_* persist between bursts; they are cleared only at their own grant or at reset.
- grant_isa and grant_data are never both 1.

Optional Feature:
DDR_ARB_ISA_PRIO_EN
- Defined: fixed priority. ISA wins every simultaneous request in IDLE; the round-robin pointer is unused. Instruction fetch stalls are minimised; DATA may starve.
- Undefined: round-robin as above.

Test Plan:
- Single ISA burst: ISA_read_req=1, addr=0x80, len=4, DDR returns 4 beats then finish -> rd_burst_req until first beat, rd_burst_addr=0x80, rd_burst_len=4; rd_cnt_isa 1,2,3,4 one cycle after each beat; grant_isa drops after req falls; rd_cnt_data stays 0.
- Simultaneous requests after reset: both req=1, ISA len=2, DATA len=3 -> ISA served first, then DATA; second round with both high serves DATA first. With DDR_ARB_ISA_PRIO_EN, ISA is served first both times.
- Zero length: DATA_read_req=1, len=0 -> no rd_burst_req; grant_data=1 for ≥1 cycle; rd_cnt_data=0; returns to IDLE after req falls.
- Reset mid-burst: rst=1 after 2 of 8 beats -> next cycle all outputs 0, state IDLE. Remaining beats produce no strobes.
- Early finish/overrun: len=4 with finish after beat 3 -> DONE with rd_cnt=3. Finish coincident with beat 4 -> beat 4 is delivered, rd_cnt=4.
